// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: unit tags, result-entry layout, helpers.
// Build option ALU_RESULT_PARITY_EN adds a per-entry parity bit above the data field.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Unit tags, same encoding as the ALU_FUN field that drives the decoder
    localparam logic [1:0] ARITH = 2'b00;
    localparam logic [1:0] LOGIC = 2'b01;
    localparam logic [1:0] CMP   = 2'b10;
    localparam logic [1:0] SHIFT = 2'b11;

    localparam int TAG_W     = 2;
    localparam int ZERO_OFS  = 0;
    localparam int CARRY_OFS = 1;
    localparam int TAG_OFS   = 2;
    localparam int DATA_OFS  = 4;

`ifdef ALU_RESULT_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    function automatic int entry_w(input int width);
        return DATA_OFS + width + PAR_W;
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Decoder-side inputs and consumer-side handshake of the ALU result stage.
// Parity_OUT exists only when ALU_RESULT_PARITY_EN is defined.
interface alu_result_stage_if #(
    parameter int WIDTH = alu_pkg::DEFAULT_WIDTH,
    parameter int ERR_W = 8
);
    logic             Arith_En;
    logic             Logic_En;
    logic             CMP_En;
    logic             Shift_En;
    logic [WIDTH-1:0] Arith_OUT;
    logic             Carry_OUT;
    logic [WIDTH-1:0] Logic_OUT;
    logic [WIDTH-1:0] CMP_OUT;
    logic [WIDTH-1:0] Shift_OUT;
    logic             In_Valid;
    logic             In_Ready;
    logic [WIDTH-1:0] ALU_OUT;
    logic [1:0]       Unit_Tag;
    logic             Carry_Flag;
    logic             Zero_Flag;
    logic             Out_Valid;
    logic             Out_Ready;
    logic             Sel_Err;
    logic [ERR_W-1:0] Err_Cnt;
`ifdef ALU_RESULT_PARITY_EN
    logic             Parity_OUT;
`endif

    modport slave (
`ifdef ALU_RESULT_PARITY_EN
        output Parity_OUT,
`endif
        input  Arith_En, Logic_En, CMP_En, Shift_En,
        input  Arith_OUT, Carry_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
        input  In_Valid, Out_Ready,
        output In_Ready, ALU_OUT, Unit_Tag, Carry_Flag, Zero_Flag,
        output Out_Valid, Sel_Err, Err_Cnt
    );

    modport master (
`ifdef ALU_RESULT_PARITY_EN
        input  Parity_OUT,
`endif
        output Arith_En, Logic_En, CMP_En, Shift_En,
        output Arith_OUT, Carry_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
        output In_Valid, Out_Ready,
        input  In_Ready, ALU_OUT, Unit_Tag, Carry_Flag, Zero_Flag,
        input  Out_Valid, Sel_Err, Err_Cnt
    );

endinterface

// File: rtl/alu_result_fifo.sv
// Generic WIDTH x DEPTH synchronous FIFO with a registered head output.
// DEPTH must be a power of two so the pointers wrap by overflow.
module alu_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = head_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        head_d   = head_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Reading the next-state array forwards a push that lands on the new head;
        // when the FIFO drains, the head keeps the last popped entry.
        if (cnt_d != '0) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: selects the enabled unit's result, tags/flags it, queues it, counts bad selects.
// Defining ALU_RESULT_PARITY_EN adds Parity_OUT, stored per entry at capture.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input logic               CLK,
    input logic               RST,
    alu_result_stage_if.slave bus
);
    localparam int ENTRY_W = entry_w(WIDTH);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [3:0]         en_vec;
    logic               sel_ok;
    logic [WIDTH-1:0]   sel_result;
    logic [1:0]         sel_tag;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] entry_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               sel_err_q, sel_err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    assign en_vec = {bus.Shift_En, bus.CMP_En, bus.Logic_En, bus.Arith_En};
    assign sel_ok = is_onehot4(en_vec);

    always_comb begin
        sel_result = bus.Arith_OUT;
        sel_tag    = ARITH;
        case (en_vec)
            4'b0010: begin
                sel_result = bus.Logic_OUT;
                sel_tag    = LOGIC;
            end
            4'b0100: begin
                sel_result = bus.CMP_OUT;
                sel_tag    = CMP;
            end
            4'b1000: begin
                sel_result = bus.Shift_OUT;
                sel_tag    = SHIFT;
            end
            default: begin
                sel_result = bus.Arith_OUT;
                sel_tag    = ARITH;
            end
        endcase
    end

    always_comb begin
        entry_in                      = '0;
        entry_in[ZERO_OFS]            = (sel_result == '0);
        entry_in[CARRY_OFS]           = bus.Carry_OUT & bus.Arith_En;
        entry_in[TAG_OFS +: TAG_W]    = sel_tag;
        entry_in[DATA_OFS +: WIDTH]   = sel_result;
`ifdef ALU_RESULT_PARITY_EN
        entry_in[DATA_OFS + WIDTH]    = ^sel_result;
`endif
    end

    // In_Ready depends only on stored occupancy, never on Out_Ready
    assign bus.In_Ready = ~fifo_full;
    assign push         = bus.In_Valid & ~fifo_full & sel_ok;
    assign pop          = ~fifo_empty & bus.Out_Ready;

    alu_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .wdata (entry_in),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (entry_head)
    );

    assign bus.Out_Valid  = ~fifo_empty;
    assign bus.ALU_OUT    = entry_head[DATA_OFS +: WIDTH];
    assign bus.Unit_Tag   = entry_head[TAG_OFS +: TAG_W];
    assign bus.Carry_Flag = entry_head[CARRY_OFS];
    assign bus.Zero_Flag  = entry_head[ZERO_OFS];
`ifdef ALU_RESULT_PARITY_EN
    assign bus.Parity_OUT = entry_head[DATA_OFS + WIDTH];
`endif

    always_comb begin
        sel_err_d = bus.In_Valid & ~sel_ok;
        err_cnt_d = err_cnt_q;
        if (sel_err_d && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sel_err_q <= sel_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.Sel_Err = sel_err_q;
    assign bus.Err_Cnt = err_cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed pushes queue expected entries, a negedge monitor checks the head.
// A second instance with ERR_W=2 shares the stimulus to exercise error-counter saturation.
module tb_alu_result_stage;

    localparam logic [3:0] EN_A = 4'b0001;
    localparam logic [3:0] EN_L = 4'b0010;
    localparam logic [3:0] EN_C = 4'b0100;
    localparam logic [3:0] EN_S = 4'b1000;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  tag;
        logic        carry;
        logic        zero;
        logic        parity;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   err_a;
    int   err_b;
    exp_t sb_q[$];

    alu_result_stage_if #(.WIDTH(16), .ERR_W(8)) bus_a ();
    alu_result_stage_if #(.WIDTH(16), .ERR_W(2)) bus_b ();

    alu_result_stage #(.WIDTH(16), .DEPTH(2), .ERR_W(8)) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
    alu_result_stage #(.WIDTH(16), .DEPTH(2), .ERR_W(2)) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

    assign bus_b.Arith_En  = bus_a.Arith_En;
    assign bus_b.Logic_En  = bus_a.Logic_En;
    assign bus_b.CMP_En    = bus_a.CMP_En;
    assign bus_b.Shift_En  = bus_a.Shift_En;
    assign bus_b.Arith_OUT = bus_a.Arith_OUT;
    assign bus_b.Carry_OUT = bus_a.Carry_OUT;
    assign bus_b.Logic_OUT = bus_a.Logic_OUT;
    assign bus_b.CMP_OUT   = bus_a.CMP_OUT;
    assign bus_b.Shift_OUT = bus_a.Shift_OUT;
    assign bus_b.In_Valid  = bus_a.In_Valid;
    assign bus_b.Out_Ready = bus_a.Out_Ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic tb_onehot(input logic [3:0] en);
        return (en == EN_A) || (en == EN_L) || (en == EN_C) || (en == EN_S);
    endfunction

    function automatic logic [1:0] tb_tag(input logic [3:0] en);
        case (en)
            EN_L:    return 2'b01;
            EN_C:    return 2'b10;
            EN_S:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // One cycle of stimulus, applied just after a rising edge; returns just after the next edge.
    task automatic drive(input logic [3:0] en, input logic [15:0] d, input logic cy,
                         input logic vld, input logic rdy, input logic exp_rdy);
        logic exp_err;
        exp_t e;
        bus_a.Arith_En  = en[0];
        bus_a.Logic_En  = en[1];
        bus_a.CMP_En    = en[2];
        bus_a.Shift_En  = en[3];
        bus_a.Arith_OUT = en[0] ? d : (d ^ 16'h5A5A);
        bus_a.Logic_OUT = en[1] ? d : (d ^ 16'hA5A5);
        bus_a.CMP_OUT   = en[2] ? d : (d ^ 16'h0F0F);
        bus_a.Shift_OUT = en[3] ? d : (d ^ 16'hF0F0);
        bus_a.Carry_OUT = cy;
        bus_a.In_Valid  = vld;
        bus_a.Out_Ready = rdy;
        chk("in_ready", {31'd0, bus_a.In_Ready}, {31'd0, exp_rdy});
        exp_err = vld && !tb_onehot(en);
        @(posedge clk);
        #1;
        if (vld && exp_rdy && tb_onehot(en)) begin
            e.data   = d;
            e.tag    = tb_tag(en);
            e.carry  = cy & en[0];
            e.zero   = (d == 16'h0000);
            e.parity = ^d;
            sb_q.push_back(e);
        end
        if (exp_err) begin
            if (err_a != 255) err_a++;
            if (err_b != 3) err_b++;
        end
        chk("sel_err", {31'd0, bus_a.Sel_Err}, {31'd0, exp_err});
        chk("err_cnt_a", {24'd0, bus_a.Err_Cnt}, err_a);
        chk("err_cnt_b", {30'd0, bus_b.Err_Cnt}, err_b);
    endtask

    task automatic idle(input logic rdy, input logic exp_rdy);
        drive(4'b0000, 16'h0000, 1'b0, 1'b0, rdy, exp_rdy);
    endtask

    task automatic check_reset_state();
        chk("rst_alu_out", {16'd0, bus_a.ALU_OUT}, 32'd0);
        chk("rst_tag", {30'd0, bus_a.Unit_Tag}, 32'd0);
        chk("rst_carry", {31'd0, bus_a.Carry_Flag}, 32'd0);
        chk("rst_zero", {31'd0, bus_a.Zero_Flag}, 32'd0);
        chk("rst_out_valid", {31'd0, bus_a.Out_Valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus_a.In_Ready}, 32'd1);
        chk("rst_sel_err", {31'd0, bus_a.Sel_Err}, 32'd0);
        chk("rst_err_cnt_a", {24'd0, bus_a.Err_Cnt}, 32'd0);
        chk("rst_err_cnt_b", {30'd0, bus_b.Err_Cnt}, 32'd0);
`ifdef ALU_RESULT_PARITY_EN
        chk("rst_parity", {31'd0, bus_a.Parity_OUT}, 32'd0);
`endif
    endtask

    // Monitor: head must match the oldest expected entry; pops on handshake.
    always @(negedge clk) begin
        chk("out_valid", {31'd0, bus_a.Out_Valid}, {31'd0, (sb_q.size() != 0)});
        if (bus_a.Out_Valid && (sb_q.size() != 0)) begin
            chk("alu_out", {16'd0, bus_a.ALU_OUT}, {16'd0, sb_q[0].data});
            chk("unit_tag", {30'd0, bus_a.Unit_Tag}, {30'd0, sb_q[0].tag});
            chk("carry_flag", {31'd0, bus_a.Carry_Flag}, {31'd0, sb_q[0].carry});
            chk("zero_flag", {31'd0, bus_a.Zero_Flag}, {31'd0, sb_q[0].zero});
`ifdef ALU_RESULT_PARITY_EN
            chk("parity", {31'd0, bus_a.Parity_OUT}, {31'd0, sb_q[0].parity});
`endif
            if (bus_a.Out_Ready) begin
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        err_a   = 0;
        err_b   = 0;
        rst     = 1'b1;
        bus_a.Arith_En  = 1'b0;
        bus_a.Logic_En  = 1'b0;
        bus_a.CMP_En    = 1'b0;
        bus_a.Shift_En  = 1'b0;
        bus_a.Arith_OUT = '0;
        bus_a.Carry_OUT = 1'b0;
        bus_a.Logic_OUT = '0;
        bus_a.CMP_OUT   = '0;
        bus_a.Shift_OUT = '0;
        bus_a.In_Valid  = 1'b0;
        bus_a.Out_Ready = 1'b0;

        // reset for two cycles
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state();

        // single arith result of zero with carry
        drive(EN_A, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // fill with consumer stalled, third push refused
        drive(EN_L, 16'h00FF, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(EN_S, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(EN_A, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        chk("hold_alu_out", {16'd0, bus_a.ALU_OUT}, 32'h1234);
        chk("hold_tag", {30'd0, bus_a.Unit_Tag}, 32'd3);

        // full with simultaneous push attempt and pop, then streaming across wrap
        drive(EN_C, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(EN_A, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(EN_L, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(EN_L, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(EN_S, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(EN_C, 16'h0004, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(EN_A, 16'h8005, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // illegal selects: two enables, none, ignored when not valid, then all four
        drive(4'b0101, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(4'b0000, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(4'b0101, 16'h3333, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(4'b1111, 16'h4444, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(4'b1111, 16'h4444, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(4'b1111, 16'h4444, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        chk("err_final_a", {24'd0, bus_a.Err_Cnt}, 32'd5);
        chk("err_final_b", {30'd0, bus_b.Err_Cnt}, 32'd3);

        // two entries queued, then reset discards them
        drive(EN_C, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(EN_L, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1'b0, 1'b0);
        rst = 1'b1;
        chk("pre_rst_in_ready", {31'd0, bus_a.In_Ready}, 32'd0);
        @(posedge clk);
        #1;
        sb_q.delete();
        err_a = 0;
        err_b = 0;
        rst   = 1'b0;
        check_reset_state();

        // operation after reset
        drive(EN_S, 16'h00A0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
